instr_fetch_decode: RTL and testbench



---
 rtl/instr_fetch_decode_pkg.sv | 16 +
 rtl/instr_fetch_decode_mem.sv | 17 +
 rtl/instr_fetch_decode.sv | 82 ++++++++
 tb/tb_instr_fetch_decode.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// instr_fetch_decode_pkg: opcodes, instruction field positions and FSM states for the fetch/decode stage
package instr_fetch_decode_pkg;
    localparam logic [1:0] OP_LI   = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_NOP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 11;
    localparam int RS_HI  = 10;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
endpackage

// File: rtl/instr_fetch_decode_mem.sv
// instr_mem: program store with synchronous write and combinational read; contents survive reset
module instr_mem #(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);
    logic [15:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: load/run/halt FSM, PC and IR, with combinational li/addi/nop/halt decode
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int IMEM_DEPTH = 16,
    localparam int AW = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Prog_We,
    input  logic [AW-1:0] Prog_Addr,
    input  logic [15:0]   Prog_Data,
    input  logic          Start,
    input  logic          Stall,
    output logic          ALUSrc,
    output logic [2:0]    Read_Reg,
    output logic [2:0]    Write_Reg,
    output logic [7:0]    Imm_Data,
    output logic          RegWrite,
    output logic          Instr_Valid,
    output logic [AW-1:0] PC,
    output logic          Halted
);
    state_t        state, state_next;
    logic [AW-1:0] pc_next;
    logic [15:0]   ir, ir_next, rdata;
    logic          valid, valid_next;
    logic [1:0]    op;

    instr_mem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_mem (
        .clk(clk),
        .we(Prog_We & (state == IDLE)),
        .waddr(Prog_Addr),
        .wdata(Prog_Data),
        .raddr(PC),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            PC    <= '0;
            ir    <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            PC    <= pc_next;
            ir    <= ir_next;
            valid <= valid_next;
        end

    // A fetched halt parks PC on its own address; a stall freezes everything.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        ir_next    = ir;
        valid_next = valid;
        if (state == RUN) begin
            if (!Stall) begin
                ir_next    = rdata;
                valid_next = 1'b1;
                if (rdata[OP_HI:OP_LO] == OP_HALT) state_next = HALT;
                else pc_next = PC + 1'b1;
            end
        end else begin
            if (state == HALT) valid_next = 1'b0;
            if (Start) begin
                state_next = RUN;
                pc_next    = '0;
            end
        end
    end

    assign op          = ir[OP_HI:OP_LO];
    assign ALUSrc      = op == OP_ADDI;
    assign Imm_Data    = ir[IMM_HI:IMM_LO];
    assign Read_Reg    = ir[RS_HI:RS_LO];
    assign Write_Reg   = ir[RD_HI:RD_LO];
    assign RegWrite    = valid & (op == OP_LI | op == OP_ADDI);
    assign Instr_Valid = valid;
    assign Halted      = state == HALT;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: scenario tasks with a decode scoreboard queue for the fetch/decode stage
module tb_instr_fetch_decode;
    typedef struct packed {
        logic       alusrc;
        logic [2:0] rs;
        logic [2:0] rd;
        logic [7:0] imm;
        logic       rw;
    } dec_t;

    logic        clk = 1'b0, rst_n = 1'b0, Prog_We = 1'b0, Start = 1'b0, Stall = 1'b0;
    logic [3:0]  Prog_Addr = '0;
    logic [15:0] Prog_Data = '0;
    logic        ALUSrc, RegWrite, Instr_Valid, Halted;
    logic [2:0]  Read_Reg, Write_Reg;
    logic [7:0]  Imm_Data;
    logic [3:0]  PC;

    int   checks = 0, passed = 0;
    dec_t sb[$];
    dec_t exp_d, obs, hold;

    instr_fetch_decode dut (
        .clk(clk), .rst_n(rst_n), .Prog_We(Prog_We), .Prog_Addr(Prog_Addr), .Prog_Data(Prog_Data),
        .Start(Start), .Stall(Stall), .ALUSrc(ALUSrc), .Read_Reg(Read_Reg), .Write_Reg(Write_Reg),
        .Imm_Data(Imm_Data), .RegWrite(RegWrite), .Instr_Valid(Instr_Valid), .PC(PC), .Halted(Halted)
    );

    always #5 clk = ~clk;

    function automatic dec_t model(input logic [15:0] w);
        dec_t d;
        d.alusrc = w[15:14] == 2'b01;
        d.rs     = w[10:8];
        d.rd     = w[13:11];
        d.imm    = w[7:0];
        d.rw     = w[15] == 1'b0;
        return d;
    endfunction

    function automatic dec_t observe();
        return {ALUSrc, Read_Reg, Write_Reg, Imm_Data, RegWrite};
    endfunction

    task tick;
        @(posedge clk);
        #1;
    endtask

    task write_mem(input logic [3:0] a, input logic [15:0] d);
        Prog_We = 1'b1; Prog_Addr = a; Prog_Data = d;
        tick();
        Prog_We = 1'b0;
    endtask

    task pulse_start;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task do_reset;
        sb.delete();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task pop_exp;
        exp_d = sb.size() != 0 ? sb.pop_front() : '1;
    endtask

    task test_reset;
        tick();
        checks++; if (observe() !== '0) $display("FAIL reset_decode: got %h want 0", observe()); else passed++;
        checks++; if (Instr_Valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", Instr_Valid); else passed++;
        checks++; if (PC !== 4'd0) $display("FAIL reset_pc: got %0d want 0", PC); else passed++;
        checks++; if (Halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", Halted); else passed++;
        rst_n = 1'b1;
    endtask

    task test_basic;
        write_mem(4'd0, 16'h0805);
        write_mem(4'd1, 16'h5103);
        write_mem(4'd2, 16'hC000);
        sb.push_back(model(16'h0805));
        sb.push_back(model(16'h5103));
        sb.push_back(model(16'hC000));
        pulse_start();
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (Instr_Valid) begin
                pop_exp(); obs = observe();
                checks++; if (obs !== exp_d) $display("FAIL basic_decode c%0d: got %h want %h", i, obs, exp_d); else passed++;
            end
            if (i == 3) begin
                checks++; if (Halted !== 1'b1 || PC !== 4'd2) $display("FAIL basic_halt: got halted=%b pc=%0d want 1/2", Halted, PC); else passed++;
            end
            if (i == 4) begin
                checks++; if (Instr_Valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", Instr_Valid); else passed++;
            end
        end
        checks++; if (sb.size() != 0) $display("FAIL basic_sb_left: got %0d want 0", sb.size()); else passed++;
    endtask

    task test_stall;
        sb.push_back(model(16'h0805));
        sb.push_back(model(16'h5103));
        sb.push_back(model(16'hC000));
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            tick();
            pop_exp(); obs = observe();
            checks++; if (obs !== exp_d || Instr_Valid !== 1'b1) $display("FAIL stall_pre c%0d: got %h v=%b want %h v=1", i, obs, Instr_Valid, exp_d); else passed++;
        end
        hold = model(16'h5103);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = observe();
            checks++; if (PC !== 4'd2 || Instr_Valid !== 1'b1 || obs !== hold) $display("FAIL stall_hold c%0d: got pc=%0d v=%b %h want pc=2 v=1 %h", i, PC, Instr_Valid, obs, hold); else passed++;
        end
        Stall = 1'b0;
        tick();
        pop_exp(); obs = observe();
        checks++; if (obs !== exp_d || Halted !== 1'b1) $display("FAIL stall_resume: got %h h=%b want %h h=1", obs, Halted, exp_d); else passed++;
        tick();
        checks++; if (Instr_Valid !== 1'b0 || sb.size() != 0) $display("FAIL stall_end: got v=%b left=%0d want 0/0", Instr_Valid, sb.size()); else passed++;
    endtask

    task test_wrap;
        logic wrapped;
        logic [3:0] prev;
        do_reset();
        for (int a = 0; a < 16; a++) write_mem(4'(a), 16'h8000);
        for (int i = 0; i < 20; i++) sb.push_back(model(16'h8000));
        pulse_start();
        wrapped = 1'b0;
        prev = PC;
        for (int i = 1; i <= 20; i++) begin
            tick();
            pop_exp(); obs = observe();
            checks++; if (obs !== exp_d || Instr_Valid !== 1'b1 || RegWrite !== 1'b0 || PC !== 4'(i)) $display("FAIL wrap c%0d: got %h v=%b rw=%b pc=%0d want %h v=1 rw=0 pc=%0d", i, obs, Instr_Valid, RegWrite, PC, exp_d, 4'(i)); else passed++;
            if (prev == 4'd15 && PC == 4'd0) wrapped = 1'b1;
            prev = PC;
        end
        checks++; if (wrapped !== 1'b1) $display("FAIL wrap_seen: got %b want 1", wrapped); else passed++;
    endtask

    task test_prog_ignore;
        do_reset();
        write_mem(4'd0, 16'h0805);
        write_mem(4'd1, 16'h5103);
        write_mem(4'd2, 16'hC000);
        pulse_start();
        Prog_We = 1'b1; Prog_Addr = 4'd0; Prog_Data = 16'h0FFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Halted) break;
        end
        tick();
        tick();
        Prog_We = 1'b0;
        checks++; if (Halted !== 1'b1) $display("FAIL ignore_halted: got %b want 1", Halted); else passed++;
        sb.push_back(model(16'h0805));
        pulse_start();
        tick();
        pop_exp(); obs = observe();
        checks++; if (obs !== exp_d || Instr_Valid !== 1'b1) $display("FAIL ignore_restart: got %h v=%b want %h v=1", obs, Instr_Valid, exp_d); else passed++;
    endtask

    task test_same_cycle;
        do_reset();
        Prog_We = 1'b1; Prog_Addr = 4'd0; Prog_Data = 16'h08AA; Start = 1'b1;
        tick();
        Prog_We = 1'b0; Start = 1'b0;
        sb.push_back(model(16'h08AA));
        tick();
        pop_exp(); obs = observe();
        checks++; if (obs !== exp_d) $display("FAIL same_decode: got %h want %h", obs, exp_d); else passed++;
        checks++; if (Imm_Data !== 8'hAA || Write_Reg !== 3'd1 || Instr_Valid !== 1'b1) $display("FAIL same_fields: got imm=%h rd=%0d v=%b want aa/1/1", Imm_Data, Write_Reg, Instr_Valid); else passed++;
    endtask

    task test_async_reset;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (observe() !== '0 || Instr_Valid !== 1'b0) $display("FAIL async_decode: got %h v=%b want 0/0", observe(), Instr_Valid); else passed++;
        checks++; if (PC !== 4'd0 || Halted !== 1'b0) $display("FAIL async_state: got pc=%0d h=%b want 0/0", PC, Halted); else passed++;
        #2;
        rst_n = 1'b1;
        tick();
        sb.push_back(model(16'h08AA));
        sb.push_back(model(16'h5103));
        pulse_start();
        tick();
        pop_exp(); obs = observe();
        checks++; if (obs !== exp_d || PC !== 4'd1) $display("FAIL async_rerun0: got %h pc=%0d want %h pc=1", obs, PC, exp_d); else passed++;
        tick();
        pop_exp(); obs = observe();
        checks++; if (obs !== exp_d || PC !== 4'd2) $display("FAIL async_rerun1: got %h pc=%0d want %h pc=2", obs, PC, exp_d); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_prog_ignore();
        test_same_cycle();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
